cla_result_fifo: RTL
====================

CLA_RESULT_FIFO -- requirements
Module: cla_result_fifo

Interface
REQ-001 Parameter: DEPTH, default 4, number of result entries (power of two, >= 2).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous and active-high.
REQ-004 Port: in_valid  input  1  registered adder output is a new result this cycle.
REQ-005 Port: in_s  input  32  registered sum from the upstream 32-bit CLA stage.
REQ-006 Port: in_co  input  1  registered carry-out from the upstream CLA stage.
REQ-007 Port: in_a_msb  input  1  bit 31 of operand a, delayed to align with in_s.
REQ-008 Port: in_b_msb  input  1  bit 31 of operand b, delayed to align with in_s.
REQ-009 Port: out_valid  output  1  head entry available.
REQ-010 Port: out_ready  input  1  consumer takes head entry when out_valid is also high.
REQ-011 Port: out_s  output  32  head entry sum.
REQ-012 Port: out_flags  output  4  head entry flags {N,Z,C,V}, N in bit 3.
REQ-013 Port: count  output  clog2(DEPTH)+1  current occupancy.
REQ-014 Port: full  output  1  count == DEPTH.
REQ-015 Port: drop_cnt  output  8  number of results discarded because the FIFO was full.

Function
REQ-016 Flag generation is combinational at the input, stored with the entry: N=in_s[31]; Z=(in_s==0); C=in_co; V=(in_a_msb==in_b_msb)&&(in_s[31]!=in_a_msb).
REQ-017 Push occurs when in_valid && (!full || pop), where pop = out_valid && out_ready.
REQ-018 Pop removes the head entry at the clock edge; there is no effect when out_valid=0.
REQ-019 The output is first-word-fall-through: out_valid = (count!=0), and out_s/out_flags show the head entry in the same cycle it becomes valid.
REQ-020 Latency: a push at edge k makes out_valid high after edge k if the FIFO was empty.
REQ-021 Simultaneous push and pop when not empty: the entry is accepted and count is unchanged.
REQ-022 Simultaneous push and pop when full: the entry is accepted, the head leaves, and count stays DEPTH with no drop.
REQ-023 Push and pop in the same cycle when empty: only the push takes effect (out_valid was 0).
REQ-024 in_valid when full and no pop: the entry is discarded, the FIFO is unchanged, and drop_cnt increments.
REQ-025 drop_cnt saturates at 255 and never wraps.
REQ-026 Read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH; count is tracked separately.
REQ-027 out_s and out_flags are don't-care while out_valid=0 but are driven to no X after reset.
REQ-028 Order is strict FIFO; entries are never reordered or duplicated.

Reset
REQ-029 While rst is high: pointers=0, count=0, out_valid=0, full=0, drop_cnt=0, and storage is cleared to 0, so out_s=0 and out_flags=0.
REQ-030 Reset asserted mid-operation takes effect immediately (asynchronously), discarding all stored entries; pushes and pops are ignored until the first edge after rst deasserts.

Verification
REQ-031 Reset, then push s=48C0EBA4, co=0, a_msb=0, b_msb=0 -> next cycle out_valid=1, out_s=48C0EBA4, out_flags=0000, count=1.
REQ-032 Push s=00000000, co=1, a_msb=1, b_msb=0 -> out_flags=0110 (Z=1, C=1, V=0); push s=80000000, co=0, a_msb=0, b_msb=0 -> out_flags=1001 (N=1, V=1).
REQ-033 out_ready=0, push 5 results with DEPTH=4 -> count=4, full=1, drop_cnt=1; pops then return the first 4 results in order.
REQ-034 When full, in_valid=1 and out_ready=1 in the same cycle -> count stays 4, drop_cnt unchanged, and the new entry appears last.
REQ-035 Continuous in_valid=1 with out_ready=0 for 300 cycles -> drop_cnt=255 (saturated), count=4.
REQ-036 With count=3, assert rst between edges -> out_valid=0 and count=0 immediately; after release, one push yields count=1 with correct data.

Source files
------------

// File: rtl/cla_result_fifo.sv
// Result FIFO behind the 32-bit CLA stage: captures sum plus NZCV flags,
// first-word-fall-through output, counts results lost on overflow.
module cla_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              in_s,
  input  logic                     in_co,
  input  logic                     in_a_msb,
  input  logic                     in_b_msb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_s,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_N = CW'(DEPTH);

  logic [31:0]   mem_s [DEPTH];
  logic [3:0]    mem_f [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [3:0]    in_flags;
  logic          push;
  logic          pop;
  logic          drop;

  // N, Z, C, V; V is signed overflow seen from operand and sum signs
  assign in_flags = {
    in_s[31],
    in_s == 32'd0,
    in_co,
    (in_a_msb == in_b_msb) && (in_s[31] != in_a_msb)
  };

  assign out_valid = count != '0;
  assign full      = count == FULL_N;
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;
  assign out_s     = mem_s[rd_ptr];
  assign out_flags = mem_f[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_s[i] <= '0;
        mem_f[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_s[wr_ptr] <= in_s;
        mem_f[wr_ptr] <= in_flags;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (!push && pop)
        count <= count - 1'b1;
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
